ex_stage_mc: RTL and testbench
==============================

Name: ex_stage_mc

Overview:
Parametrised, registered execute stage for the RISC-V pipeline, successor to the single-cycle combinational EX stage. Performs operand forwarding, immediate select and ALU operations. Single-cycle ops complete into an EX/MEM output register; MUL runs on an iterative shift-add unit that stalls upstream. Sits between the ID/EX register and the MEM stage, and supports downstream stall and flush.

Parameters:
XLEN, 32, datapath width (power of two, >=8)
REG_ADDR_W, 5, destination register index width

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  ID/EX holds a valid instruction
stall_in  input  1  downstream hold; output register must not change
flush  input  1  kill in-flight work and output register
PC  input  XLEN  instruction PC
rs1_data  input  XLEN  register-file operand A
rs2_data  input  XLEN  register-file operand B
imm_ext  input  XLEN  sign-extended immediate
rd_in  input  REG_ADDR_W  destination register
ALUSrc  input  1  1: B operand = imm_ext
ALUControl  input  4  operation code
ForwardA  input  2  00 rs1_data, 01 ALUResult_MEM, 10 WriteData_WB, 11 rs1_data
ForwardB  input  2  same encoding, for rs2
ALUResult_MEM  input  XLEN  forwarded MEM-stage result
WriteData_WB  input  XLEN  forwarded WB-stage result
busy  output  1  multi-cycle op in progress; upstream holds
out_valid  output  1  output register holds a valid result
ALUResult  output  XLEN  registered result
Zero  output  1  registered (result == 0)
rs2_final  output  XLEN  registered forwarded B, before the ALUSrc mux (store data)
rd_out  output  REG_ADDR_W  registered rd_in
PC_out  output  XLEN  registered PC

Behaviour:
- Reset: every output register and busy go to 0, and the FSM goes to IDLE.
- Operands: A = fwd(ForwardA). Bf = fwd(ForwardB). B = ALUSrc ? imm_ext : Bf.
- ALUControl codes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR
  - 0101 SLT: signed, result 1 or 0, zero-extended
  - 0110 SLL, 0111 SRL: shift amount is B[log2(XLEN)-1:0]
  - 1000 MUL: low XLEN bits of the product
  - 1001 DIVU, 1010 REMU: optional, see below
  - other codes: result 0
- All arithmetic wraps modulo 2^XLEN.
- Accept condition: in_valid and !busy and !stall_in and !flush.
- Single-cycle op: on an accepting edge the output register loads the result, Zero, Bf, rd_in and PC, and sets out_valid=1. Latency is 1 clock.
- Edge with no accept, no stall_in and no flush: out_valid <= 0 (bubble).
- FSM states: IDLE, MUL, DONE.
- IDLE->MUL: on accepting MUL.
  - Capture A, B, rd_in and PC; counter = XLEN; out_valid <= 0.
  - busy=1 from the next cycle.
- MUL: one shift-add iteration per clock; counter decrements.
  - When counter reaches 1, the next edge writes the output register (out_valid=1) and goes to IDLE if !stall_in, otherwise to DONE.
  - MUL result appears XLEN edges after acceptance.
- DONE: busy=1, result held internally. On the first edge with !stall_in, write the output register and go to IDLE.
- busy = (state != IDLE).
- stall_in=1: output register holds all values, including out_valid. The iterative unit keeps running.
- flush: highest priority below reset.
  - Next edge: out_valid=0, FSM to IDLE, busy=0, any partial product discarded.
  - Flush and in_valid on the same edge: the instruction is not accepted.
- Forwarding values are sampled only on the accept edge. Later changes do not affect a running MUL.

Optional Feature:
EX_DIVU_EN
- Defined: codes 1001 and 1010 run on an iterative restoring divider, state DIV.
  - Same timing, busy, stall, DONE and flush rules as MUL.
  - Result XLEN edges after acceptance.
  - Divisor 0: DIVU = all ones; REMU = dividend.
- Undefined: 1001 and 1010 are single-cycle ops with result 0, and the divider logic is absent.

Test Plan:
1. ADD, no forwarding: rs1_data=10, rs2_data=5, Forward=00/00, ALUSrc=0 -> next edge ALUResult=15, Zero=0, out_valid=1, rs2_final=5.
2. ForwardA=01, ALUResult_MEM=0x20, rs2_data=5, ADD -> ALUResult=0x25. ForwardB=10, WriteData_WB=4, SUB with rs1_data=10 -> ALUResult=6, rs2_final=4. SUB with 10 and rs2_data=10 -> Zero=1.
3. ALUSrc=1, imm_ext=2, ForwardB=10, WriteData_WB=4, ADD with rs1_data=10 -> ALUResult=12, rs2_final=4. SLT with -1 and imm_ext 1 -> ALUResult=1.
4. MUL 7*6 -> busy=1 for XLEN cycles, out_valid=0 meanwhile, then ALUResult=42 with out_valid=1. MUL 0xFFFFFFFF*2 -> 0xFFFFFFFE. A following ADD is accepted only after busy drops.
5. MUL with stall_in=1 held across completion -> FSM in DONE, busy=1, outputs unchanged. Release stall_in -> next edge ALUResult=42, then busy=0. flush 10 cycles into a MUL -> next edge busy=0, out_valid=0, and no result is ever produced.
6. (EX_DIVU_EN) DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5. Without the macro, the same codes give ALUResult=0 one cycle later.

Source files
------------

// File: rtl/ex_stage_mc.sv
// Registered RISC-V execute stage: forwarding, ALU, iterative shift-add MUL.
// Optional iterative DIVU/REMU unit enabled by defining EX_DIVU_EN.
module ex_stage_mc #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic                  stall_in,
    input  logic                  flush,
    input  logic [XLEN-1:0]       PC,
    input  logic [XLEN-1:0]       rs1_data,
    input  logic [XLEN-1:0]       rs2_data,
    input  logic [XLEN-1:0]       imm_ext,
    input  logic [REG_ADDR_W-1:0] rd_in,
    input  logic                  ALUSrc,
    input  logic [3:0]            ALUControl,
    input  logic [1:0]            ForwardA,
    input  logic [1:0]            ForwardB,
    input  logic [XLEN-1:0]       ALUResult_MEM,
    input  logic [XLEN-1:0]       WriteData_WB,
    output logic                  busy,
    output logic                  out_valid,
    output logic [XLEN-1:0]       ALUResult,
    output logic                  Zero,
    output logic [XLEN-1:0]       rs2_final,
    output logic [REG_ADDR_W-1:0] rd_out,
    output logic [XLEN-1:0]       PC_out
);

    localparam int SW = $clog2(XLEN);
    localparam int CW = SW + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
`ifdef EX_DIVU_EN
    localparam logic [1:0] S_DIV  = 2'd3;
`endif

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLL  = 4'b0110;
    localparam logic [3:0] OP_SRL  = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
`ifdef EX_DIVU_EN
    localparam logic [3:0] OP_DIVU = 4'b1001;
    localparam logic [3:0] OP_REMU = 4'b1010;
`endif

    logic [1:0]            state_q;
    logic [CW-1:0]         cnt_q;
    logic [XLEN-1:0]       a_q;
    logic [XLEN-1:0]       b_q;
    logic [XLEN-1:0]       acc_q;
    logic [XLEN-1:0]       bf_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [XLEN-1:0]       pc_q;
`ifdef EX_DIVU_EN
    logic                  rem_q;
`endif

    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_bf;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_res;
    logic            is_mul;
    logic            is_mc;
    logic            accept;
    logic            fin_now;
    logic            mc_wr;
    logic [XLEN-1:0] mc_res;
    logic [XLEN-1:0] mul_acc_nx;
    logic [XLEN-1:0] step_fin;
`ifdef EX_DIVU_EN
    logic            is_div;
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] div_r_nx;
    logic [XLEN-1:0] div_q_nx;
`endif

    assign busy = (state_q != S_IDLE);

    // Forwarding muxes and immediate select
    always_comb begin
        op_a = rs1_data;
        case (ForwardA)
            2'b01:   op_a = ALUResult_MEM;
            2'b10:   op_a = WriteData_WB;
            default: op_a = rs1_data;
        endcase
        op_bf = rs2_data;
        case (ForwardB)
            2'b01:   op_bf = ALUResult_MEM;
            2'b10:   op_bf = WriteData_WB;
            default: op_bf = rs2_data;
        endcase
        op_b = ALUSrc ? imm_ext : op_bf;
    end

    // Single-cycle ALU; multi-cycle and unused codes yield 0 here
    always_comb begin
        alu_res = '0;
        case (ALUControl)
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}},
                                ($signed(op_a) < $signed(op_b))};
            OP_SLL:  alu_res = op_a << op_b[SW-1:0];
            OP_SRL:  alu_res = op_a >> op_b[SW-1:0];
            default: alu_res = '0;
        endcase
    end

    assign is_mul = (ALUControl == OP_MUL);
`ifdef EX_DIVU_EN
    assign is_div = (ALUControl == OP_DIVU) || (ALUControl == OP_REMU);
    assign is_mc  = is_mul || is_div;
`else
    assign is_mc  = is_mul;
`endif
    assign accept = in_valid && !busy && !stall_in && !flush;

    // One shift-add / restore-divide step and the final-step result
    always_comb begin
        mul_acc_nx = acc_q + (b_q[0] ? a_q : '0);
        step_fin   = mul_acc_nx;
`ifdef EX_DIVU_EN
        trial = {acc_q, a_q[XLEN-1]} - {1'b0, b_q};
        if (!trial[XLEN]) begin
            div_r_nx = trial[XLEN-1:0];
            div_q_nx = {a_q[XLEN-2:0], 1'b1};
        end else begin
            div_r_nx = {acc_q[XLEN-2:0], a_q[XLEN-1]};
            div_q_nx = {a_q[XLEN-2:0], 1'b0};
        end
        if (state_q == S_DIV)
            step_fin = rem_q ? div_r_nx : div_q_nx;
`endif
    end

`ifdef EX_DIVU_EN
    assign fin_now = ((state_q == S_MUL) || (state_q == S_DIV))
                     && (cnt_q == CW'(1));
`else
    assign fin_now = (state_q == S_MUL) && (cnt_q == CW'(1));
`endif
    assign mc_res = (state_q == S_DONE) ? acc_q : step_fin;
    assign mc_wr  = !stall_in && (fin_now || (state_q == S_DONE));

    // Multi-cycle unit FSM: capture on accept, iterate, park in DONE on stall
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            bf_q    <= '0;
            rd_q    <= '0;
            pc_q    <= '0;
`ifdef EX_DIVU_EN
            rem_q   <= 1'b0;
`endif
        end else if (flush) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept && is_mc) begin
`ifdef EX_DIVU_EN
                        state_q <= is_mul ? S_MUL : S_DIV;
                        rem_q   <= (ALUControl == OP_REMU);
`else
                        state_q <= S_MUL;
`endif
                        a_q   <= op_a;
                        b_q   <= op_b;
                        acc_q <= '0;
                        cnt_q <= CW'(XLEN);
                        bf_q  <= op_bf;
                        rd_q  <= rd_in;
                        pc_q  <= PC;
                    end
                end
                S_MUL: begin
                    a_q   <= a_q << 1;
                    b_q   <= b_q >> 1;
                    acc_q <= mul_acc_nx;
                    cnt_q <= cnt_q - CW'(1);
                    if (fin_now)
                        state_q <= stall_in ? S_DONE : S_IDLE;
                end
`ifdef EX_DIVU_EN
                S_DIV: begin
                    a_q   <= div_q_nx;
                    acc_q <= div_r_nx;
                    cnt_q <= cnt_q - CW'(1);
                    if (fin_now) begin
                        acc_q   <= step_fin;
                        state_q <= stall_in ? S_DONE : S_IDLE;
                    end
                end
`endif
                S_DONE: begin
                    if (!stall_in)
                        state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // EX/MEM output register: flush > stall hold > MC result > ALU > bubble
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            ALUResult <= '0;
            Zero      <= 1'b0;
            rs2_final <= '0;
            rd_out    <= '0;
            PC_out    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (stall_in) begin
            out_valid <= out_valid;
        end else if (mc_wr) begin
            out_valid <= 1'b1;
            ALUResult <= mc_res;
            Zero      <= (mc_res == '0);
            rs2_final <= bf_q;
            rd_out    <= rd_q;
            PC_out    <= pc_q;
        end else if (accept && !is_mc) begin
            out_valid <= 1'b1;
            ALUResult <= alu_res;
            Zero      <= (alu_res == '0);
            rs2_final <= op_bf;
            rd_out    <= rd_in;
            PC_out    <= PC;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ex_stage_mc.sv
// Scoreboard bench for ex_stage_mc: forwarding, ALU ops, MUL timing,
// stall/DONE and flush behaviour; DIVU/REMU checked per EX_DIVU_EN.
module tb_ex_stage_mc;

    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        stall_in;
    logic        flush;
    logic [31:0] PC;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm_ext;
    logic [4:0]  rd_in;
    logic        ALUSrc;
    logic [3:0]  ALUControl;
    logic [1:0]  ForwardA;
    logic [1:0]  ForwardB;
    logic [31:0] ALUResult_MEM;
    logic [31:0] WriteData_WB;
    logic        busy;
    logic        out_valid;
    logic [31:0] ALUResult;
    logic        Zero;
    logic [31:0] rs2_final;
    logic [4:0]  rd_out;
    logic [31:0] PC_out;

    ex_stage_mc #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .stall_in(stall_in), .flush(flush), .PC(PC),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm_ext(imm_ext),
        .rd_in(rd_in), .ALUSrc(ALUSrc), .ALUControl(ALUControl),
        .ForwardA(ForwardA), .ForwardB(ForwardB),
        .ALUResult_MEM(ALUResult_MEM), .WriteData_WB(WriteData_WB),
        .busy(busy), .out_valid(out_valid), .ALUResult(ALUResult),
        .Zero(Zero), .rs2_final(rs2_final), .rd_out(rd_out),
        .PC_out(PC_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic [31:0] s2;
        logic [4:0]  rd;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    int   err_cnt = 0;
    int   chk_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [1:0] sel,
                                        input logic [31:0] rf);
        if (sel == 2'b01) return ALUResult_MEM;
        if (sel == 2'b10) return WriteData_WB;
        return rf;
    endfunction

    function automatic logic [31:0] model(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6: return a << b[4:0];
            4'd7: return a >> b[4:0];
            4'd8: return a * b;
`ifdef EX_DIVU_EN
            4'd9:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd10: return (b == 0) ? a : a % b;
`endif
            default: return 32'd0;
        endcase
    endfunction

    // Drive one instruction, hold it until accepted, push expectation
    task automatic send(input logic [3:0] op, input logic [4:0] rd,
                        input logic [31:0] pc);
        int w;
        exp_t e;
        logic [31:0] a, bf, b;
        @(negedge clk);
        ALUControl = op;
        rd_in      = rd;
        PC         = pc;
        in_valid   = 1'b1;
        w = 0;
        while ((busy || stall_in) && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) check("accept_timeout", 1, 0);
        a  = fwd(ForwardA, rs1_data);
        bf = fwd(ForwardB, rs2_data);
        b  = ALUSrc ? imm_ext : bf;
        e.res = model(op, a, b);
        e.z   = (e.res == 0);
        e.s2  = bf;
        e.rd  = rd;
        e.pc  = pc;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic ops(input logic [31:0] r1, input logic [31:0] r2,
                       input logic [1:0] fa, input logic [1:0] fb,
                       input logic src, input logic [31:0] im);
        rs1_data = r1;
        rs2_data = r2;
        ForwardA = fa;
        ForwardB = fb;
        ALUSrc   = src;
        imm_ext  = im;
    endtask

    // Output monitor: each unstalled, unflushed edge with out_valid is new
    initial begin
        logic st, fl, rs;
        exp_t e;
        forever begin
            @(posedge clk);
            st = stall_in;
            fl = flush;
            rs = reset;
            #1;
            if (!rs && !st && !fl && out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", {32'd0, ALUResult}, 64'hDEAD);
                end else begin
                    e = sb.pop_front();
                    check("result", ALUResult, e.res);
                    check("zero", Zero, e.z);
                    check("rs2_final", rs2_final, e.s2);
                    check("rd_out", rd_out, e.rd);
                    check("pc_out", PC_out, e.pc);
                end
            end
        end
    end

    initial begin
        int cnt, ovhi, w;
        logic [31:0] prev;
        reset = 1'b1;
        in_valid = 1'b0;
        stall_in = 1'b0;
        flush = 1'b0;
        PC = 0;
        rd_in = 0;
        ALUControl = 0;
        ALUResult_MEM = 0;
        WriteData_WB = 0;
        ops(0, 0, 2'b00, 2'b00, 1'b0, 0);
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_result", ALUResult, 0);
        check("rst_zero", Zero, 0);
        check("rst_rs2f", rs2_final, 0);
        check("rst_rd", rd_out, 0);
        check("rst_pc", PC_out, 0);
        reset = 1'b0;

        // plain ADD, forwarding, SUB zero, immediate, SLT
        ops(10, 5, 2'b00, 2'b00, 1'b0, 0);
        send(4'd0, 5'd1, 32'h100);
        ALUResult_MEM = 32'h20;
        WriteData_WB  = 32'd4;
        ops(10, 5, 2'b01, 2'b00, 1'b0, 0);
        send(4'd0, 5'd2, 32'h104);
        ops(10, 5, 2'b00, 2'b10, 1'b0, 0);
        send(4'd1, 5'd3, 32'h108);
        ops(10, 10, 2'b00, 2'b00, 1'b0, 0);
        send(4'd1, 5'd4, 32'h10C);
        ops(10, 5, 2'b00, 2'b10, 1'b1, 2);
        send(4'd0, 5'd5, 32'h110);
        ops(32'hFFFF_FFFF, 5, 2'b00, 2'b00, 1'b1, 1);
        send(4'd5, 5'd6, 32'h114);
        ops(32'h8000_0001, 35, 2'b00, 2'b00, 1'b0, 0);
        send(4'd7, 5'd7, 32'h118);
        send(4'd6, 5'd8, 32'h11C);
        send(4'd15, 5'd9, 32'h120);

        // MUL timing: busy exactly XLEN cycles, no output meanwhile
        ops(7, 6, 2'b00, 2'b00, 1'b0, 0);
        send(4'd8, 5'd10, 32'h200);
        ALUResult_MEM = 32'h1234;
        rs1_data = 99;
        cnt = 0;
        ovhi = 0;
        while (busy && cnt < 100) begin
            if (out_valid) ovhi++;
            cnt++;
            @(negedge clk);
        end
        check("mul_busy_cycles", cnt, XLEN);
        check("mul_outvalid_low", ovhi, 0);

        // MUL then ADD back to back; ADD must wait for busy to drop
        ops(32'hFFFF_FFFF, 2, 2'b00, 2'b00, 1'b0, 0);
        send(4'd8, 5'd11, 32'h204);
        ops(3, 4, 2'b00, 2'b00, 1'b0, 0);
        send(4'd0, 5'd12, 32'h208);

        // stall across MUL completion parks in DONE
        repeat (2) @(negedge clk);
        prev = ALUResult;
        ops(7, 6, 2'b00, 2'b00, 1'b0, 0);
        send(4'd8, 5'd13, 32'h300);
        stall_in = 1'b1;
        repeat (XLEN + 3) @(negedge clk);
        check("done_busy", busy, 1);
        check("done_outvalid", out_valid, 0);
        check("done_result_held", ALUResult, prev);
        stall_in = 1'b0;
        @(negedge clk);
        check("done_release_busy", busy, 0);

        // flush mid-MUL: nothing ever appears
        ops(9, 9, 2'b00, 2'b00, 1'b0, 0);
        send(4'd8, 5'd14, 32'h400);
        void'(sb.pop_back());
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", busy, 0);
        check("flush_outvalid", out_valid, 0);
        repeat (XLEN + 5) @(negedge clk);
        check("flush_no_result", out_valid, 0);

        // flush with in_valid on the same edge: not accepted
        ops(1, 1, 2'b00, 2'b00, 1'b0, 0);
        ALUControl = 4'd0;
        in_valid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b0;
        check("flush_blocks_accept", out_valid, 0);

        // divide codes: iterative when enabled, else single-cycle zero
        ops(100, 7, 2'b00, 2'b00, 1'b0, 0);
        send(4'd9, 5'd15, 32'h500);
        send(4'd10, 5'd16, 32'h504);
        ops(5, 0, 2'b00, 2'b00, 1'b0, 0);
        send(4'd9, 5'd17, 32'h508);
        send(4'd10, 5'd18, 32'h50C);

        // randomised mix
        for (int i = 0; i < 30; i++) begin
            ALUResult_MEM = $urandom;
            WriteData_WB  = $urandom;
            ops($urandom, (i % 5 == 0) ? 32'd0 : $urandom,
                2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), $urandom);
            send(4'($urandom_range(0, 11)), 5'($urandom),
                 $urandom);
        end

        w = 0;
        while (sb.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
